tmds_encoder_pipe: RTL

//  Pipelined, multi-channel HDMI 1.4a TMDS encoder (5.4 encoding, 5.2.2.1/5.2.3.3 guard bands).

---
 rtl/tmds_encoder_pipe.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/tmds_encoder_pipe.sv
// Two-stage, multi-lane HDMI TMDS encoder: video 8b/10b with running disparity, TERC4, guards, control.
// Optional define TMDS_PRBS_EN adds prbs_sel and a 7-bit LFSR that replaces video bytes.
module tmds_encoder_pipe #(
    parameter int         NUM_CH     = 3,
    parameter logic [1:0] RESET_CTRL = 2'b00
) (
    input  logic                  clk_pixel,
    input  logic                  rst_n,
    input  logic [8*NUM_CH-1:0]   video_data,
    input  logic [4*NUM_CH-1:0]   data_island_data,
    input  logic [2*NUM_CH-1:0]   control_data,
    input  logic [2:0]            mode,
`ifdef TMDS_PRBS_EN
    input  logic                  prbs_sel,
`endif
    output logic [10*NUM_CH-1:0]  tmds,
    output logic [5*NUM_CH-1:0]   disparity,
    output logic                  mode_err
);

    localparam logic [2:0] MODE_CTRL   = 3'd0;
    localparam logic [2:0] MODE_VIDEO  = 3'd1;
    localparam logic [2:0] MODE_VGUARD = 3'd2;
    localparam logic [2:0] MODE_ISLAND = 3'd3;
    localparam logic [2:0] MODE_IGUARD = 3'd4;

    localparam logic [9:0] GUARD_A = 10'b1011001100;
    localparam logic [9:0] GUARD_B = 10'b0100110011;

    function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic logic [9:0] terc4_sym(input logic [3:0] n);
        case (n)
            4'h0:    return 10'b1010011100;
            4'h1:    return 10'b1001100011;
            4'h2:    return 10'b1011100100;
            4'h3:    return 10'b1011100010;
            4'h4:    return 10'b0101110001;
            4'h5:    return 10'b0100011110;
            4'h6:    return 10'b0110001110;
            4'h7:    return 10'b0100111100;
            4'h8:    return 10'b1011001100;
            4'h9:    return 10'b0100111001;
            4'hA:    return 10'b0110011100;
            4'hB:    return 10'b1011000110;
            4'hC:    return 10'b1010001110;
            4'hD:    return 10'b1001110001;
            4'hE:    return 10'b0101100011;
            default: return 10'b1011000011;
        endcase
    endfunction

    // Transition-minimising first step; q[8] = 1 marks the XOR path.
    function automatic logic [8:0] qm_enc(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] q;
        n1       = 4'($countones(d));
        use_xnor = (n1 > 4'd4) || (n1 == 4'd4 && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++)
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = ~use_xnor;
        return q;
    endfunction

    logic [7:0] w_video_byte [NUM_CH];
    logic [8:0] w_qm         [NUM_CH];
    logic [3:0] w_qm_n1      [NUM_CH];

`ifdef TMDS_PRBS_EN
    logic [6:0] r_lfsr;
    logic [6:0] w_lfsr_walk;
    logic [7:0] w_prbs_byte;
    logic       w_prbs_use;

    assign w_prbs_use = prbs_sel && (mode == MODE_VIDEO);

    // x^7 + x^6 + 1, eight steps per pixel; first generated bit lands in bit 0.
    always_comb begin
        w_lfsr_walk = r_lfsr;
        w_prbs_byte = '0;
        for (int i = 0; i < 8; i++) begin
            w_prbs_byte[i] = w_lfsr_walk[6] ^ w_lfsr_walk[5];
            w_lfsr_walk    = {w_lfsr_walk[5:0], w_prbs_byte[i]};
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n)          r_lfsr <= 7'h7F;
        else if (w_prbs_use) r_lfsr <= w_lfsr_walk;
    end
`endif

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
`ifdef TMDS_PRBS_EN
            w_video_byte[k] = w_prbs_use ? w_prbs_byte : video_data[8*k +: 8];
`else
            w_video_byte[k] = video_data[8*k +: 8];
`endif
            w_qm[k]    = qm_enc(w_video_byte[k]);
            w_qm_n1[k] = 4'($countones(w_qm[k][7:0]));
        end
    end

    logic [2:0] r_mode;
    logic [1:0] r_ctrl [NUM_CH];
    logic [3:0] r_nib  [NUM_CH];
    logic [8:0] r_qm   [NUM_CH];
    logic [3:0] r_n1   [NUM_CH];

    // NOTE: every element of these small per-lane arrays is reset; they are flops, not RAM,
    // and the idle pipe must emit the reset control symbol deterministically.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= MODE_CTRL;
            for (int k = 0; k < NUM_CH; k++) begin
                r_ctrl[k] <= RESET_CTRL;
                r_nib[k]  <= '0;
                r_qm[k]   <= '0;
                r_n1[k]   <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every stage samples pre-edge values.
            r_mode <= mode;
            for (int k = 0; k < NUM_CH; k++) begin
                r_ctrl[k] <= control_data[2*k +: 2];
                r_nib[k]  <= data_island_data[4*k +: 4];
                r_qm[k]   <= w_qm[k];
                r_n1[k]   <= w_qm_n1[k];
            end
        end
    end

    logic signed [4:0] r_acc     [NUM_CH];
    logic        [9:0] r_tmds    [NUM_CH];
    logic              r_mode_err;
    logic signed [4:0] w_diff    [NUM_CH];
    logic signed [4:0] w_acc_nxt [NUM_CH];
    logic        [9:0] w_sym     [NUM_CH];

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            // NOTE: defaults first so no path through the case leaves a latch.
            w_sym[k]     = ctrl_sym(r_ctrl[k]);
            w_acc_nxt[k] = '0;
            w_diff[k]    = $signed({r_n1[k], 1'b0}) - 5'sd8;   // N1 - N0
            case (r_mode)
                MODE_VIDEO: begin
                    if (r_acc[k] == 5'sd0 || r_n1[k] == 4'd4) begin
                        if (r_qm[k][8]) begin
                            w_sym[k]     = {2'b01, r_qm[k][7:0]};
                            w_acc_nxt[k] = r_acc[k] + w_diff[k];
                        end else begin
                            w_sym[k]     = {2'b10, ~r_qm[k][7:0]};
                            w_acc_nxt[k] = r_acc[k] - w_diff[k];
                        end
                    end else if ((r_acc[k] > 5'sd0 && r_n1[k] > 4'd4) ||
                                 (r_acc[k] < 5'sd0 && r_n1[k] < 4'd4)) begin
                        w_sym[k]     = {1'b1, r_qm[k][8], ~r_qm[k][7:0]};
                        w_acc_nxt[k] = r_acc[k] - w_diff[k] + (r_qm[k][8] ? 5'sd2 : 5'sd0);
                    end else begin
                        w_sym[k]     = {1'b0, r_qm[k][8], r_qm[k][7:0]};
                        w_acc_nxt[k] = r_acc[k] + w_diff[k] - (r_qm[k][8] ? 5'sd0 : 5'sd2);
                    end
                end
                MODE_VGUARD: w_sym[k] = (k % 3 == 1) ? GUARD_B : GUARD_A;
                MODE_ISLAND: w_sym[k] = terc4_sym(r_nib[k]);
                MODE_IGUARD: w_sym[k] = (k % 3 == 0) ? terc4_sym({2'b11, r_ctrl[k]}) : GUARD_B;
                default:     w_sym[k] = ctrl_sym(r_ctrl[k]);
            endcase
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_err <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_tmds[k] <= ctrl_sym(RESET_CTRL);
                r_acc[k]  <= '0;
            end
        end else begin
            r_mode_err <= (r_mode > MODE_IGUARD);
            for (int k = 0; k < NUM_CH; k++) begin
                r_tmds[k] <= w_sym[k];
                r_acc[k]  <= w_acc_nxt[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            tmds[10*k +: 10]     = r_tmds[k];
            disparity[5*k +: 5]  = r_acc[k];
        end
    end

    assign mode_err = r_mode_err;

endmodule
